// File: rtl/pio_osr_fifo.sv
// pio_osr_fifo: PIO transmit path made of a TX FIFO feeding an output shift
// register with programmable direction, OUT width, autopull and PULL modes.
// State-machine side requests only act when the divider pulse is high.
module pio_osr_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level,
    input  logic                       pulse_en,
    input  logic                       shift_right,
    input  logic                       autopull,
    input  logic [CNT_W-1:0]           pull_thresh,
    input  logic                       out_en,
    input  logic [CNT_W-1:0]           out_cnt,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       pull_en,
    input  logic                       pull_block,
    input  logic [DATA_W-1:0]          x_data,
    output logic                       stall,
    output logic [CNT_W-1:0]           osr_count,
    input  logic                       flag_clr,
    output logic                       tx_over,
    output logic                       tx_stall
);

    localparam int                AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DATA_W);
    localparam logic [CNT_W:0]    FULL_SUM = (CNT_W + 1)'(DATA_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [DATA_W-1:0] r_osr;
    logic [CNT_W-1:0]  r_osr_count;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_tx_over;
    logic              r_tx_stall;

    logic [DATA_W-1:0] w_head;
    logic [AW:0]       w_diff;
    logic [CNT_W-1:0]  w_n;
    logic [CNT_W-1:0]  w_t;
    logic              w_pull_req;
    logic              w_out_req;
    logic              w_exhausted;
    logic              w_pop;
    logic              w_push_acc;
    logic              w_over_set;
    logic              w_stall;
    logic              w_load_osr;
    logic              w_out_acc;
    logic [DATA_W-1:0] w_src;
    logic [CNT_W-1:0]  w_base;
    logic [CNT_W:0]    w_sum;
    logic [DATA_W-1:0] w_new_osr;
    logic [CNT_W-1:0]  w_new_cnt;
    logic [DATA_W-1:0] w_new_out;

    // The extra wrap bit on each pointer separates full from empty.
    assign w_head = r_mem[r_rd_ptr[AW-1:0]];
    assign w_diff = r_wr_ptr - r_rd_ptr;
    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign level  = w_diff;

    // A zero count or threshold encodes a full word.
    assign w_n         = (out_cnt == '0) ? FULL_CNT : out_cnt;
    assign w_t         = (pull_thresh == '0) ? FULL_CNT : pull_thresh;
    assign w_exhausted = autopull && (r_osr_count >= w_t);
    assign w_pull_req  = pulse_en && pull_en;
    assign w_out_req   = pulse_en && out_en && !pull_en;

    // A full FIFO still takes a push when the head leaves on the same edge.
    assign w_push_acc = push && (!full || w_pop);
    assign w_over_set = push && full && !w_pop;

    // Decode PULL/OUT into OSR, counter, FIFO-pop and stall actions.
    always_comb begin
        w_pop      = 1'b0;
        w_stall    = 1'b0;
        w_load_osr = 1'b0;
        w_out_acc  = 1'b0;
        w_src      = r_osr;
        w_base     = r_osr_count;
        w_sum      = '0;
        w_new_osr  = r_osr;
        w_new_cnt  = r_osr_count;
        w_new_out  = r_out_data;
        if (w_pull_req) begin
            if (!(autopull && (r_osr_count < w_t))) begin
                if (!empty) begin
                    w_new_osr  = w_head;
                    w_new_cnt  = '0;
                    w_load_osr = 1'b1;
                    w_pop      = 1'b1;
                end else if (pull_block) begin
                    w_stall = 1'b1;
                end else begin
                    w_new_osr  = x_data;
                    w_new_cnt  = '0;
                    w_load_osr = 1'b1;
                end
            end
        end else if (w_out_req) begin
            if (w_exhausted && empty) begin
                w_stall = 1'b1;
            end else begin
                if (w_exhausted) begin
                    w_src  = w_head;
                    w_base = '0;
                    w_pop  = 1'b1;
                end
                if (shift_right) begin
                    w_new_out = w_src & ({DATA_W{1'b1}} >> (FULL_CNT - w_n));
                    w_new_osr = w_src >> w_n;
                end else begin
                    w_new_out = w_src >> (FULL_CNT - w_n);
                    w_new_osr = w_src << w_n;
                end
                w_sum      = {1'b0, w_base} + {1'b0, w_n};
                w_new_cnt  = (w_sum > FULL_SUM) ? FULL_CNT : w_sum[CNT_W-1:0];
                w_load_osr = 1'b1;
                w_out_acc  = 1'b1;
            end
        end
    end

    // FIFO storage is not reset; the pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // FIFO pointers advance on accepted pushes and pops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // OSR, consumed-bit counter and the registered OUT result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_osr       <= '0;
            r_osr_count <= FULL_CNT;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_load_osr) begin
                r_osr       <= w_new_osr;
                r_osr_count <= w_new_cnt;
            end
            r_out_data  <= w_new_out;
            r_out_valid <= w_out_acc;
        end
    end

    // Sticky flags; a new event beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_over  <= 1'b0;
            r_tx_stall <= 1'b0;
        end else begin
            r_tx_over  <= w_over_set || (r_tx_over && !flag_clr);
            r_tx_stall <= w_stall || (r_tx_stall && !flag_clr);
        end
    end

    assign stall     = w_stall;
    assign osr_count = r_osr_count;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign tx_over   = r_tx_over;
    assign tx_stall  = r_tx_stall;

endmodule

// File: tb/tb_pio_osr_fifo.sv
// tb_pio_osr_fifo: directed and randomized stimulus for pio_osr_fifo, checked
// against a queue-based reference model; OUT results go through a scoreboard.
module tb_pio_osr_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              full;
    logic              empty;
    logic [2:0]        level;
    logic              pulse_en;
    logic              shift_right;
    logic              autopull;
    logic [CNT_W-1:0]  pull_thresh;
    logic              out_en;
    logic [CNT_W-1:0]  out_cnt;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              pull_en;
    logic              pull_block;
    logic [DATA_W-1:0] x_data;
    logic              stall;
    logic [CNT_W-1:0]  osr_count;
    logic              flag_clr;
    logic              tx_over;
    logic              tx_stall;

    int                assertCount = 0;
    int                failCount   = 0;

    logic [31:0]       expQ[$];
    logic [31:0]       modelQ[$];
    logic [31:0]       modelOsr;
    int                modelCount;
    bit                modelOver;
    bit                modelStall;

    pio_osr_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data),
        .full(full), .empty(empty), .level(level), .pulse_en(pulse_en),
        .shift_right(shift_right), .autopull(autopull), .pull_thresh(pull_thresh),
        .out_en(out_en), .out_cnt(out_cnt), .out_data(out_data), .out_valid(out_valid),
        .pull_en(pull_en), .pull_block(pull_block), .x_data(x_data), .stall(stall),
        .osr_count(osr_count), .flag_clr(flag_clr), .tx_over(tx_over), .tx_stall(tx_stall)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every out_valid pulse consumes one expected word.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL spurious_out_valid: got out_data %0h, expected no output at %0t", out_data, $time);
            end else begin
                checkOutput("out_data", out_data, expQ.pop_front());
            end
        end
    end

    task automatic clearInputs();
        push       = 1'b0;
        push_data  = '0;
        pulse_en   = 1'b1;
        out_en     = 1'b0;
        out_cnt    = '0;
        pull_en    = 1'b0;
        pull_block = 1'b0;
        x_data     = '0;
        flag_clr   = 1'b0;
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic doReset();
        reset = 1'b1;
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_osr_count", osr_count, 32);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_level", level, 0);
        checkOutput("rst_tx_over", tx_over, 0);
        checkOutput("rst_tx_stall", tx_stall, 0);
        expQ.delete();
        modelQ.delete();
        modelOsr   = '0;
        modelCount = 32;
        modelOver  = 1'b0;
        modelStall = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One clock of stimulus: predict, compare combinational outputs, step the model.
    task automatic applyStimulus();
        int          n;
        int          t;
        int          base;
        bit          expStall;
        bit          popNow;
        bit          outAcc;
        bit          exhausted;
        logic [63:0] src;
        logic [63:0] outWord;
        logic [63:0] newOsr;
        int          newCount;
        #1;
        n        = (out_cnt == 0) ? 32 : int'(out_cnt);
        t        = (pull_thresh == 0) ? 32 : int'(pull_thresh);
        expStall = 1'b0;
        popNow   = 1'b0;
        outAcc   = 1'b0;
        newOsr   = {32'd0, modelOsr};
        newCount = modelCount;
        if (pulse_en && pull_en) begin
            if (!(autopull && modelCount < t)) begin
                if (modelQ.size() > 0) begin
                    newOsr   = {32'd0, modelQ[0]};
                    newCount = 0;
                    popNow   = 1'b1;
                end else if (pull_block) begin
                    expStall = 1'b1;
                end else begin
                    newOsr   = {32'd0, x_data};
                    newCount = 0;
                end
            end
        end else if (pulse_en && out_en) begin
            exhausted = autopull && (modelCount >= t);
            if (exhausted && modelQ.size() == 0) begin
                expStall = 1'b1;
            end else begin
                if (exhausted) begin
                    src    = {32'd0, modelQ[0]};
                    base   = 0;
                    popNow = 1'b1;
                end else begin
                    src  = {32'd0, modelOsr};
                    base = modelCount;
                end
                if (shift_right) begin
                    outWord = src & ((64'd1 << n) - 64'd1);
                    newOsr  = src >> n;
                end else begin
                    outWord = src >> (32 - n);
                    newOsr  = (src << n) & 64'hFFFF_FFFF;
                end
                newCount = (base + n > 32) ? 32 : base + n;
                outAcc   = 1'b1;
                expQ.push_back(outWord[31:0]);
            end
        end
        checkOutput("stall", stall, expStall);
        checkOutput("full", full, modelQ.size() == DEPTH);
        checkOutput("empty", empty, modelQ.size() == 0);
        checkOutput("level", level, modelQ.size());
        checkOutput("osr_count", osr_count, modelCount);
        checkOutput("tx_over", tx_over, modelOver);
        checkOutput("tx_stall", tx_stall, modelStall);
        if (popNow) void'(modelQ.pop_front());
        modelOver  = (modelOver && !flag_clr) || (push && modelQ.size() == DEPTH);
        if (push && modelQ.size() < DEPTH) modelQ.push_back(push_data);
        modelStall = (modelStall && !flag_clr) || expStall;
        modelOsr   = newOsr[31:0];
        modelCount = newCount;
        @(posedge clk);
        #1;
        checkOutput("out_valid", out_valid, outAcc);
    endtask

    task automatic doPush(input logic [31:0] d);
        clearInputs();
        push      = 1'b1;
        push_data = d;
        applyStimulus();
    endtask

    task automatic doOut(input int cnt);
        clearInputs();
        out_en  = 1'b1;
        out_cnt = CNT_W'(cnt);
        applyStimulus();
    endtask

    task automatic doIdle();
        clearInputs();
        applyStimulus();
    endtask

    initial begin
        clearInputs();
        shift_right = 1'b1;
        autopull    = 1'b0;
        pull_thresh = '0;

        // Reset state, fill to full, overflow and flag clear.
        doReset();
        for (int i = 0; i < 5; i++) doPush(32'h1000_0000 + i);
        clearInputs();
        flag_clr = 1'b1;
        applyStimulus();
        doIdle();

        // Autopull, LSB first, full-word threshold.
        doReset();
        autopull    = 1'b1;
        shift_right = 1'b1;
        pull_thresh = '0;
        doPush(32'hA5A5_F00F);
        for (int i = 0; i < 4; i++) doOut(8);
        doIdle();

        // Autopull, MSB first, threshold 16; third OUT finds the FIFO empty.
        doReset();
        shift_right = 1'b0;
        pull_thresh = 6'd16;
        doPush(32'h1234_5678);
        doPush(32'h9ABC_DEF0);
        for (int i = 0; i < 3; i++) doOut(16);
        autopull = 1'b0;
        doOut(16);
        doIdle();

        // Stall on empty FIFO, then retry after a push.
        doReset();
        autopull    = 1'b1;
        shift_right = 1'b1;
        pull_thresh = '0;
        doOut(8);
        clearInputs();
        out_en    = 1'b1;
        out_cnt   = 6'd8;
        push      = 1'b1;
        push_data = 32'h0000_00FF;
        applyStimulus();
        doOut(8);
        doIdle();

        // PULL: blocking stall, non-blocking X load, autopull no-op.
        doReset();
        autopull = 1'b0;
        clearInputs();
        pull_en    = 1'b1;
        pull_block = 1'b1;
        applyStimulus();
        clearInputs();
        pull_en = 1'b1;
        x_data  = 32'hCAFE_BABE;
        applyStimulus();
        doOut(8);
        autopull = 1'b1;
        clearInputs();
        pull_en = 1'b1;
        x_data  = 32'h1111_1111;
        applyStimulus();
        doOut(8);
        doIdle();

        // Divider pulse low gates requests; push on full with a same-cycle pop.
        clearInputs();
        pulse_en = 1'b0;
        out_en   = 1'b1;
        out_cnt  = 6'd8;
        applyStimulus();
        pull_en = 1'b1;
        applyStimulus();
        for (int i = 0; i < 4; i++) doPush(32'h5555_0000 + i);
        pull_thresh = 6'd8;
        clearInputs();
        out_en    = 1'b1;
        out_cnt   = 6'd4;
        push      = 1'b1;
        push_data = 32'h7777_7777;
        applyStimulus();
        doIdle();

        // Mid-operation reset drops FIFO contents and an in-flight out_valid.
        doOut(4);
        doReset();
        doIdle();

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            if (i % 40 == 0) begin
                autopull    = 1'($urandom_range(0, 1));
                pull_thresh = CNT_W'($urandom_range(0, 32));
            end
            clearInputs();
            push        = ($urandom_range(0, 99) < 45);
            push_data   = $urandom;
            pulse_en    = ($urandom_range(0, 99) < 80);
            shift_right = 1'($urandom_range(0, 1));
            out_en      = ($urandom_range(0, 99) < 55);
            out_cnt     = CNT_W'($urandom_range(0, 32));
            pull_en     = ($urandom_range(0, 99) < 15);
            pull_block  = 1'($urandom_range(0, 1));
            x_data      = $urandom;
            flag_clr    = ($urandom_range(0, 99) < 10);
            applyStimulus();
        end

        doIdle();
        @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
